qr_a_loader: RTL and testbench

- Input-side responder for the qr_cordic core.
- Accepts one 8x4 A matrix as a valid/ready sample stream, stores it, then asserts en to start qr_cordic.
- Serves qr_cordic's rd_A read requests from internal storage until qr_cordic raises valid.
- Replaces the behavioural A ROM in the synthesizable top level, so new matrices can be loaded at run time.

---
 rtl/qr_pkg.sv | 25 ++
 rtl/qr_a_regfile.sv | 35 +++
 rtl/qr_a_loader.sv | 136 +++++++++++++
 tb/tb_qr_a_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared constants and types for the qr_cordic input-side loader.
package qr_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 4;
  localparam int unsigned ROW_AW = 3;
  localparam int unsigned COL_AW = 2;
  localparam int unsigned A_LEN  = ROWS * COLS;
  localparam int unsigned A_AW   = $clog2(A_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } ld_state_e;

  // Row-major flat index of an A element.
  function automatic logic [A_AW-1:0] a_index(input logic [ROW_AW-1:0] row,
                                               input logic [COL_AW-1:0] col);
    return A_AW'(row) * A_AW'(COLS) + A_AW'(col);
  endfunction

endpackage

// File: rtl/qr_a_regfile.sv
// A matrix storage: rising-edge write port, falling-edge registered read port.
module qr_a_regfile
  import qr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [A_AW-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [A_AW-1:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [A_LEN];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Falling-edge capture so the data is settled at the consumer's next rising edge.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/qr_a_loader.sv
// Streams one A matrix into storage, starts qr_cordic and serves its reads.
// Optional run-length counter output enabled by QR_A_CYCLE_CNT_EN.
module qr_a_loader
  import qr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              en,
  input  logic              rd_A,
  input  logic [ROW_AW-1:0] rd_A_row_addr,
  input  logic [COL_AW-1:0] rd_A_col_addr,
  output logic [DATA_W-1:0] rd_A_data,
  input  logic              valid,
  output logic              busy,
  output logic              done,
`ifdef QR_A_CYCLE_CNT_EN
  output logic [9:0]        run_cycles,
`endif
  output logic              load_err
);

  localparam logic [A_AW-1:0] LastIdx = A_AW'(A_LEN - 1);

  ld_state_e       state_q, state_d;
  logic [A_AW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic [A_AW-1:0] wr_addr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = cnt_q;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (in_last) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            cnt_d   = A_AW'(1);
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + A_AW'(1);
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            err_d   = !in_last;
            state_d = in_last ? StRun : StIdle;
          end else if (in_last) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRun: begin
        if (valid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Decoded straight from the state register, so reset clears them without a clock.
  assign en       = (state_q == StRun);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign load_err = err_q;

  qr_a_regfile u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (in_data),
    .re_i    (rd_A && (state_q == StRun)),
    .raddr_i (a_index(rd_A_row_addr, rd_A_col_addr)),
    .rdata_o (rd_A_data)
  );

`ifdef QR_A_CYCLE_CNT_EN
  logic [9:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q != StRun && state_d == StRun) begin
      run_cnt_d = '0;
    end else if (state_q == StRun && run_cnt_q != 10'h3FF) begin
      run_cnt_d = run_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign run_cycles = run_cnt_q;
`endif

endmodule

// File: tb/tb_qr_a_loader.sv
// Directed/randomised bench for qr_a_loader against a frame-level reference model.
module tb_qr_a_loader;
  import qr_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              en;
  logic              rd_A = 1'b0;
  logic [ROW_AW-1:0] rd_A_row_addr = '0;
  logic [COL_AW-1:0] rd_A_col_addr = '0;
  logic [DATA_W-1:0] rd_A_data;
  logic              valid = 1'b0;
  logic              busy;
  logic              done;
  logic              load_err;
`ifdef QR_A_CYCLE_CNT_EN
  logic [9:0]        run_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_mem [A_LEN];

  always #5 clk = ~clk;

  qr_a_loader u_dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .en            (en),
    .rd_A          (rd_A),
    .rd_A_row_addr (rd_A_row_addr),
    .rd_A_col_addr (rd_A_col_addr),
    .rd_A_data     (rd_A_data),
    .valid         (valid),
    .busy          (busy),
    .done          (done),
`ifdef QR_A_CYCLE_CNT_EN
    .run_cycles    (run_cycles),
`endif
    .load_err      (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives n beats; in_last on beat last_at (1-based, 0 = never). A frame is good
  // only if exactly A_LEN beats arrive with in_last on the final one.
  task automatic send_frame(input int n, input int last_at, input bit stalls, input bit seq);
    int  data [A_LEN];
    bit  ok;
    for (int b = 1; b <= n; b++) begin
      if (stalls) begin
        int s = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (s) begin
          tick();
          if (b > 1) check("stall_busy", busy, 1);
        end
      end
      data[b-1] = seq ? (b - 1) : $urandom_range(1, (1 << DATA_W) - 1);
      in_valid  = 1'b1;
      in_data   = DATA_W'(data[b-1]);
      in_last   = (b == last_at);
      check("beat_ready", in_ready, 1);
      tick();
      if (b == 1 && last_at != 1) check("first_beat_clears_err", load_err, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ok = (n == A_LEN) && (last_at == A_LEN);
    if (ok) begin
      for (int i = 0; i < A_LEN; i++) exp_mem[i] = data[i];
    end
    check("frame_err", load_err, !ok);
    check("frame_en", en, ok);
    check("frame_busy", busy, ok);
    check("frame_ready", in_ready, !ok);
  endtask

  task automatic read_check(input int r, input int c);
    rd_A          = 1'b1;
    rd_A_row_addr = ROW_AW'(r);
    rd_A_col_addr = COL_AW'(c);
    tick();
    rd_A = 1'b0;
    check("rd_data", rd_A_data, exp_mem[r*COLS + c]);
    check("run_ready", in_ready, 0);
  endtask

  task automatic finish_run();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("done_pulse", done, 1);
    check("done_en", en, 0);
    check("done_busy", busy, 1);
    check("done_ready", in_ready, 0);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
  endtask

  initial begin
    int a;
    int b;
    logic [DATA_W-1:0] held;

    // Reset values
    #1 rst = 1'b0;
    #10;
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", load_err, 0);
    check("rst_rdata", rd_A_data, 0);
    check("rst_ready", in_ready, 1);
    #2 rst = 1'b1;
    tick();

    // Nominal frame 0..31
    send_frame(A_LEN, A_LEN, 1'b0, 1'b1);
    read_check(5, 2);
    check("nominal_r5c2", rd_A_data, 22);
    finish_run();

    // Random data with stalls, full read-back sweep
    send_frame(A_LEN, A_LEN, 1'b1, 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) read_check(r, c);
    end
    held = rd_A_data;
    tick();
    check("rd_hold", rd_A_data, held);
    // Read alongside valid in the last RUN cycle is still served
    a = $urandom_range(0, A_LEN - 1);
    rd_A          = 1'b1;
    rd_A_row_addr = ROW_AW'(a / COLS);
    rd_A_col_addr = COL_AW'(a % COLS);
    valid         = 1'b1;
    tick();
    valid = 1'b0;
    check("last_rd_done", done, 1);
    check("last_rd_data", rd_A_data, exp_mem[a]);
    b = (a + 1) % A_LEN;
    rd_A_row_addr = ROW_AW'(b / COLS);
    rd_A_col_addr = COL_AW'(b % COLS);
    tick();
    rd_A = 1'b0;
    check("rd_outside_run", rd_A_data, exp_mem[a]);
    check("after_done_idle", busy, 0);

    // Framing errors
    send_frame(10, 10, 1'b0, 1'b0);
    repeat (3) tick();
    check("early_last_no_en", en, 0);
    send_frame(A_LEN, 0, 1'b0, 1'b0);
    send_frame(1, 1, 1'b0, 1'b0);
    send_frame(A_LEN, A_LEN, 1'b1, 1'b0);
    read_check(7, 3);
    finish_run();

    // Async reset mid-LOAD
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("midload_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midload_rst_busy", busy, 0);
    check("midload_rst_en", en, 0);
    check("midload_rst_ready", in_ready, 1);
    #2 rst = 1'b1;
    repeat (3) tick();
    check("midload_no_en", en, 0);

    // Async reset mid-RUN
    send_frame(A_LEN, A_LEN, 1'b0, 1'b0);
    read_check(3, 1);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_en", en, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_rdata", rd_A_data, 0);
    #2 rst = 1'b1;
    repeat (3) tick();
    check("midrun_no_en", en, 0);
    send_frame(A_LEN, A_LEN, 1'b1, 1'b0);
    read_check(6, 0);
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
